// File: rtl/pitch_detector_pkg.sv
// Shared pitch constants for the pitch adjuster / detector pair.
//   SEMITONE_RATIO : 2^(1/12) in 16.16 fixed point (truncating recurrence)
//   NOTE_*         : note encoding, C = 0 ... B = 11
//   MAX_NOTE       : highest note index
//   MAX_OCTAVE     : highest octave index
package pitch_detector_pkg;

   localparam logic [31:0] SEMITONE_RATIO = 32'h10F39;

   localparam logic [3:0] NOTE_C  = 4'd0;
   localparam logic [3:0] NOTE_CS = 4'd1;
   localparam logic [3:0] NOTE_D  = 4'd2;
   localparam logic [3:0] NOTE_DS = 4'd3;
   localparam logic [3:0] NOTE_E  = 4'd4;
   localparam logic [3:0] NOTE_F  = 4'd5;
   localparam logic [3:0] NOTE_FS = 4'd6;
   localparam logic [3:0] NOTE_G  = 4'd7;
   localparam logic [3:0] NOTE_GS = 4'd8;
   localparam logic [3:0] NOTE_A  = 4'd9;
   localparam logic [3:0] NOTE_AS = 4'd10;
   localparam logic [3:0] NOTE_B  = 4'd11;

   localparam logic [3:0] MAX_NOTE   = NOTE_B;
   localparam logic [1:0] MAX_OCTAVE = 2'd3;

endpackage

// File: rtl/pitch_detector_semitone_step.sv
// semitone_step: one step of the truncating semitone recurrence.
//   value_i : 20-bit pitch step value
//   step_o  : (value_i * SEMITONE_RATIO) >> 16, truncated to 20 bits
// Shared with the pitch adjuster so both blocks walk identical step values.
module semitone_step
   import pitch_detector_pkg::*;
(
   input  logic [19:0] value_i,
   output logic [19:0] step_o
);

   // 20b x 17b needs 37 bits; the shifted result always fits in 20.
   assign step_o = 20'(({17'd0, value_i} * 37'(SEMITONE_RATIO)) >> 16);

endmodule

// File: rtl/pitch_detector.sv
// pitch_detector: classifies a raw pitch step value into (octave, note)
// relative to a reference C0 pitch, by walking octaves (doubling) and then
// semitones (semitone_step) until the next step would exceed the pitch.
//   clk             : system clock
//   reset_n         : async active-low reset
//   request_valid   : request strobe, accepted only while idle
//   reference_pitch : C0 step value, captured at acceptance
//   pitch           : step value to classify, captured at acceptance
//   busy            : high from acceptance edge until result edge
//   detected_note   : 0-11, C = 0
//   detected_octave : 0-3
//   below_range     : pitch < reference, or reference == 0
//   detected_valid  : level, result fields stable while high
//
// state     | meaning
// ST_IDLE   | waiting for request, result outputs held
// ST_OCTAVE | range check (first cycle), then double base per octave
// ST_NOTE   | step candidate by one semitone per cycle
module pitch_detector
   import pitch_detector_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        request_valid,
   input  logic [15:0] reference_pitch,
   input  logic [15:0] pitch,
   output logic        busy,
   output logic [3:0]  detected_note,
   output logic [1:0]  detected_octave,
   output logic        below_range,
   output logic        detected_valid
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OCTAVE = 2'd1,
      ST_NOTE   = 2'd2
   } state_e;

   state_e      state_q;
   logic [15:0] pitch_q;
   logic [19:0] base_q;
   logic [19:0] cand_q;
   logic [3:0]  note_q;
   logic [1:0]  oct_q;
   logic        first_q;

   logic [19:0] step_d;
   logic [20:0] base_dbl;
   logic [19:0] pitch_ext;

   semitone_step u_step (
      .value_i (cand_q),
      .step_o  (step_d)
   );

   assign base_dbl  = {base_q, 1'b0};
   assign pitch_ext = {4'd0, pitch_q};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         pitch_q         <= '0;
         base_q          <= '0;
         cand_q          <= '0;
         note_q          <= '0;
         oct_q           <= '0;
         first_q         <= 1'b0;
         busy            <= 1'b0;
         detected_note   <= '0;
         detected_octave <= '0;
         below_range     <= 1'b0;
         detected_valid  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (request_valid) begin
                  pitch_q        <= pitch;
                  base_q         <= {4'd0, reference_pitch};
                  note_q         <= '0;
                  oct_q          <= '0;
                  first_q        <= 1'b1;
                  busy           <= 1'b1;
                  detected_valid <= 1'b0;
                  below_range    <= 1'b0;
                  state_q        <= ST_OCTAVE;
               end
            end

            ST_OCTAVE: begin
               first_q <= 1'b0;
               // On the first cycle base still holds the captured reference.
               if (first_q && ((base_q == '0) || (pitch_ext < base_q))) begin
                  below_range     <= 1'b1;
                  detected_note   <= '0;
                  detected_octave <= '0;
                  detected_valid  <= 1'b1;
                  busy            <= 1'b0;
                  state_q         <= ST_IDLE;
               end else if ((oct_q < MAX_OCTAVE) && ({5'd0, pitch_q} >= base_dbl)) begin
                  base_q <= base_dbl[19:0];
                  oct_q  <= oct_q + 2'd1;
               end else begin
                  cand_q  <= base_q;
                  state_q <= ST_NOTE;
               end
            end

            ST_NOTE: begin
               if ((note_q < MAX_NOTE) && (pitch_ext >= step_d)) begin
                  cand_q <= step_d;
                  note_q <= note_q + 4'd1;
               end else begin
                  detected_note   <= note_q;
                  detected_octave <= oct_q;
                  detected_valid  <= 1'b1;
                  busy            <= 1'b0;
                  state_q         <= ST_IDLE;
               end
            end

            default: begin
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_detector.sv
// Directed self-checking bench for pitch_detector.
module tb_pitch_detector;

   logic        clk;
   logic        reset_n;
   logic        request_valid;
   logic [15:0] reference_pitch;
   logic [15:0] pitch;
   logic        busy;
   logic [3:0]  detected_note;
   logic [1:0]  detected_octave;
   logic        below_range;
   logic        detected_valid;

   int n_checks = 0;
   int n_fail   = 0;

   pitch_detector dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .request_valid   (request_valid),
      .reference_pitch (reference_pitch),
      .pitch           (pitch),
      .busy            (busy),
      .detected_note   (detected_note),
      .detected_octave (detected_octave),
      .below_range     (below_range),
      .detected_valid  (detected_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] step_fn(input logic [31:0] x);
      logic [63:0] p;
      p = 64'(x) * 64'd69433;
      return 32'(p >> 16);
   endfunction

   // Issue one request; returns the edge number where detected_valid rose.
   // poke_at > 0 strobes a competing request right after that edge.
   task automatic run_req(input logic [15:0] r, input logic [15:0] p,
                          input int poke_at, output int lat);
      lat = -1;
      @(negedge clk);
      reference_pitch = r;
      pitch           = p;
      request_valid   = 1'b1;
      @(posedge clk);
      #1;
      request_valid = 1'b0;
      chk("busy_at_accept", busy, 1);
      chk("valid_dropped", detected_valid, 0);
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         request_valid = 1'b0;
         if (n == poke_at) begin
            request_valid   = 1'b1;
            pitch           = 16'h1000;
            reference_pitch = 16'h0000;
         end
         if (detected_valid) begin
            lat = n;
            chk("busy_fall", busy, 0);
            break;
         end else begin
            chk("busy_held", busy, 1);
         end
      end
      request_valid = 1'b0;
      chk("result_seen", detected_valid, 1);
   endtask

   initial begin
      int          lat;
      logic [31:0] x;

      reset_n         = 1'b0;
      request_valid   = 1'b0;
      reference_pitch = '0;
      pitch           = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_valid", detected_valid, 0);
      chk("rst_below", below_range, 0);
      chk("rst_note", detected_note, 0);
      chk("rst_oct", detected_octave, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // C0 exactly
      run_req(16'h1000, 16'h1000, 0, lat);
      chk("c0_note", detected_note, 0);
      chk("c0_oct", detected_octave, 0);
      chk("c0_below", below_range, 0);
      chk("c0_lat", lat, 2);

      // C# boundary: 0x1000 * 0x10F39 >> 16 = 0x10F3 = 4339
      run_req(16'h1000, 16'd4339, 0, lat);
      chk("cs_note", detected_note, 1);
      chk("cs_oct", detected_octave, 0);
      chk("cs_lat", lat, 3);
      run_req(16'h1000, 16'd4338, 0, lat);
      chk("cs_m1_note", detected_note, 0);
      chk("cs_m1_oct", detected_octave, 0);

      run_req(16'h1000, 16'h2000, 0, lat);
      chk("c1_note", detected_note, 0);
      chk("c1_oct", detected_octave, 1);
      chk("c1_lat", lat, 3);

      // Saturating corner, with a competing request strobed mid-search
      run_req(16'h1000, 16'hFFFF, 3, lat);
      chk("max_note", detected_note, 11);
      chk("max_oct", detected_octave, 3);
      chk("max_below", below_range, 0);
      chk("max_lat", lat, 16);

      run_req(16'h1000, 16'h0FFF, 0, lat);
      chk("below_flag", below_range, 1);
      chk("below_note", detected_note, 0);
      chk("below_oct", detected_octave, 0);
      chk("below_lat", lat, 1);

      run_req(16'h0000, 16'h1234, 0, lat);
      chk("ref0_below", below_range, 1);
      chk("ref0_lat", lat, 1);

      // Round trip over every note and octave
      for (int o = 0; o < 4; o++) begin
         for (int nt = 0; nt < 12; nt++) begin
            x = 32'h0800 << o;
            for (int k = 0; k < nt; k++) x = step_fn(x);
            run_req(16'h0800, x[15:0], 0, lat);
            chk("rt_note", detected_note, nt);
            chk("rt_oct", detected_octave, o);
            chk("rt_below", below_range, 0);
            chk("rt_lat", lat, o + nt + 2);
         end
      end

      // Request coinciding with the result edge is not accepted
      @(negedge clk);
      reference_pitch = 16'h1000;
      pitch           = 16'h1000;
      request_valid   = 1'b1;
      @(posedge clk);
      #1;
      request_valid = 1'b0;
      @(posedge clk);
      #1;
      request_valid = 1'b1;
      pitch         = 16'h2000;
      @(posedge clk);
      #1;
      chk("edge_valid", detected_valid, 1);
      chk("edge_busy", busy, 0);
      chk("edge_note", detected_note, 0);
      @(posedge clk);
      #1;
      request_valid = 1'b0;
      chk("next_busy", busy, 1);
      chk("next_valid", detected_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("next_not_yet", detected_valid, 0);
      @(posedge clk);
      #1;
      chk("next_valid_rise", detected_valid, 1);
      chk("next_oct", detected_octave, 1);
      chk("next_note", detected_note, 0);

      // Reset mid-search
      @(negedge clk);
      reference_pitch = 16'h1000;
      pitch           = 16'hFFFF;
      request_valid   = 1'b1;
      @(posedge clk);
      #1;
      request_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", detected_valid, 0);
      chk("mid_rst_note", detected_note, 0);
      chk("mid_rst_oct", detected_octave, 0);
      chk("mid_rst_below", below_range, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_req(16'h1000, 16'd4339, 0, lat);
      chk("post_rst_note", detected_note, 1);
      chk("post_rst_oct", detected_octave, 0);
      chk("post_rst_lat", lat, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pitch_detector.md
# pitch_detector

Inverse of the pitch adjuster. Takes a reference pitch (note C, octave 0) and an arbitrary 16-bit pitch step value, then searches iteratively for the octave (0-3) and semitone note (0-11) that the pitch falls in. The search uses the same truncating 2^(1/12) fixed-point recurrence as the adjuster, so any adjuster output fed back here returns its original note and octave exactly. It sits between the demo's pitch source and display/control logic, which need a note index from a raw pitch.

## Interface
Parameters: none.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- request_valid  in  1  request strobe; sampled only while idle.
- reference_pitch  in  16  pitch of C, octave 0; captured at acceptance.
- pitch  in  16  pitch to classify; captured at acceptance.
- busy  out  1  high from the acceptance edge until the result edge.
- detected_note  out  4  note 0-11, C=0, encoding per notes.vh.
- detected_octave  out  2  octave 0-3.
- below_range  out  1  pitch < reference_pitch, or reference_pitch == 0.
- detected_valid  out  1  level; result fields are stable while high.

## Operation
- States: IDLE, OCTAVE, NOTE.
- Registers:
  - captured pitch (16b)
  - base (20b)
  - candidate (20b)
  - note counter (4b)
  - octave counter (2b)
- IDLE, request_valid=1 (acceptance edge):
  - capture both inputs; base <= reference_pitch; octave <= 0; note <= 0.
  - detected_valid <= 0; below_range <= 0; enter OCTAVE.
- IDLE, request_valid=0: hold all outputs.
- OCTAVE, first cycle only: if reference == 0 or pitch < reference, then below_range <= 1, note/octave outputs <= 0, detected_valid <= 1, go to IDLE.
- OCTAVE, otherwise, each cycle:
  - if octave < 3 and pitch >= (base << 1): base <= base << 1, octave++.
  - else: candidate <= base, enter NOTE.
- NOTE, each cycle:
  - next = (candidate * 0x10F39) >> 16, computed at 37 bits and truncated to 20.
  - if note < 11 and pitch >= next: candidate <= next, note++.
  - else: outputs <= note/octave counters, detected_valid <= 1, go to IDLE.
- Result semantics are floor: the largest (octave, note) whose step value is <= pitch. Note saturates at 11; octave saturates at 3.
- Internal 20-bit width: base << 3 (max 19b) and products never overflow.
- request_valid while busy: ignored, no queuing. A request in the same cycle as the return to IDLE is not accepted; acceptance is possible from the next cycle.
- reset_n low at any time, including mid-search: immediately forces IDLE and clears all outputs and counters.

## Timing
- Reset values:
  - busy=0
  - detected_valid=0
  - below_range=0
  - detected_note=0
  - detected_octave=0
- Edge numbering: acceptance edge is edge 0.
- Normal result: detected_valid rises at edge octave+note+2.
  - Minimum 2 (C, octave 0).
  - Maximum 16 (octave 3, note 11).
- below_range result: detected_valid rises at edge 1.
- busy rises at edge 0 and falls on the same edge detected_valid rises.
- Inputs other than request_valid may change freely after edge 0.
- detected_valid stays high until the next acceptance edge, where it drops to 0.

## Structure
- notes.vh, shared with the adjuster:
  - SEMITONE_RATIO = 32'h10F39.
  - note encoding constants (C=0 ... B=11).
  - MAX_NOTE = 11, MAX_OCTAVE = 3.
- Sub-module semitone_step: combinational, 20-bit in, (in * SEMITONE_RATIO) >> 16 out. The adjuster is to be refactored onto it so both blocks share one recurrence.
- State encoding: localparams in this module.

## Test plan
- ref=0x1000, pitch=0x1000 -> note 0, octave 0, below_range 0; valid at edge 2.
- ref=0x1000, pitch=4339 (C# step) -> note 1, octave 0. Then pitch=4338 -> note 0, octave 0.
- ref=0x1000, pitch=0x2000 -> octave 1, note 0. Then pitch=0xFFFF -> octave 3, note 11; valid at edge 16; busy high edges 0-15.
- ref=0x1000, pitch=0x0FFF -> below_range 1, note 0, octave 0; valid at edge 1. Repeat with ref=0 -> below_range 1.
- Round trip: for every note 0-11 and octave 0-3 with ref=0x0800, drive the semitone_step chain output in as pitch -> detected note and octave match the originals exactly.
- Second request strobed while busy -> ignored, first result unchanged. Assert reset_n low at edge 5 of a long search -> outputs 0 and busy 0 immediately. After release, a fresh request completes normally.
